// File: rtl/mvprod_rr_sched.sv
// Round-robin arbiter that shares one MVProd engine between two requester FIFO pairs.
// Optional RUN watchdog enabled by defining MVPROD_SCHED_WDT_EN.
module mvprod_rr_sched #(
  parameter int OutVecLength  = 8,
  parameter int BytesPerRead  = 2,
  parameter int BytesPerWrite = 1,
  parameter int RearmCycles   = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [1:0]                 req_valid,
  input  logic [BytesPerRead*8-1:0]  in_data_0,
  input  logic [BytesPerRead*8-1:0]  in_data_1,
  output logic [1:0]                 rd_en,
  output logic [1:0]                 wrap_rd,
  output logic [1:0]                 out_wr_en,
  output logic [BytesPerWrite*8-1:0] out_wr_data,
  output logic                       mv_in_data_ready,
  output logic [BytesPerRead*8-1:0]  mv_in_data,
  input  logic                       mv_req_chunk_in,
  input  logic                       mv_req_chunk_ptr_rst,
  input  logic                       mv_req_chunk_out,
  input  logic [BytesPerWrite*8-1:0] mv_write_out_data,
  input  logic                       mv_out_vector_valid,
  output logic                       grant_id,
  output logic                       busy,
  output logic [1:0]                 done,
  output logic                       err
);

  localparam int WRITES = OutVecLength / BytesPerWrite;
  localparam int CNT_W  = $clog2(WRITES + 1);
  localparam int RCN_W  = $clog2(RearmCycles + 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WRITES - 1);
  localparam logic [RCN_W-1:0] REARM_LAST = RCN_W'(RearmCycles - 1);

  typedef enum logic [1:0] {IDLE, RUN, REARM} state_t;

  state_t           state_reg;
  logic             grant_id_reg;
  logic             last_grant_reg;
  logic [1:0]       done_reg;
  logic [CNT_W-1:0] wr_cnt_reg;
  logic [RCN_W-1:0] rearm_cnt_reg;
  logic             run;
  logic             timeout;
  logic             fwd;
  logic             grant_next;

  assign run        = (state_reg == RUN);
  assign fwd        = run && !timeout;
  assign grant_next = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];

`ifdef MVPROD_SCHED_WDT_EN
  localparam int WDT_W = $clog2(TimeoutCycles + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TimeoutCycles - 1);
  logic [WDT_W-1:0] wdt_reg;

  // Counts RUN cycles from 0, so the limit is reached on RUN cycle TimeoutCycles.
  always_ff @(posedge clk_in) begin
    if (rst_in || !run) begin
      wdt_reg <= '0;
    end else begin
      wdt_reg <= wdt_reg + WDT_W'(1);
    end
  end
  assign timeout = run && (wdt_reg == WDT_LAST);
`else
  assign timeout = 1'b0;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    logic sel;
    assign sel           = fwd && (grant_id_reg == 1'(gi));
    assign rd_en[gi]     = sel && mv_req_chunk_in;
    assign wrap_rd[gi]   = sel && mv_req_chunk_ptr_rst;
    assign out_wr_en[gi] = sel && mv_req_chunk_out;
  end

  assign mv_in_data       = !run ? '0 : (grant_id_reg ? in_data_1 : in_data_0);
  assign out_wr_data      = run ? mv_write_out_data : '0;
  assign mv_in_data_ready = run;
  assign busy             = (state_reg != IDLE);
  assign grant_id         = grant_id_reg;
  assign done             = done_reg;
  assign err              = timeout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      grant_id_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
      done_reg       <= '0;
      wr_cnt_reg     <= '0;
      rearm_cnt_reg  <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          wr_cnt_reg    <= '0;
          rearm_cnt_reg <= '0;
          if (|req_valid) begin
            grant_id_reg   <= grant_next;
            last_grant_reg <= grant_next;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          if (timeout) begin
            wr_cnt_reg <= '0;
            state_reg  <= REARM;
          end else if (mv_req_chunk_out) begin
            if (wr_cnt_reg == WR_LAST) begin
              wr_cnt_reg             <= '0;
              done_reg[grant_id_reg] <= 1'b1;
              state_reg              <= REARM;
            end else begin
              wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            end
          end
        end
        REARM: begin
          if (rearm_cnt_reg == REARM_LAST) begin
            rearm_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            rearm_cnt_reg <= rearm_cnt_reg + RCN_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // out_vector_valid is observed only; sequencing relies on the write count.
  logic unused_ok;
  assign unused_ok = &{1'b0, mv_out_vector_valid, (TimeoutCycles > 0)};

endmodule

// File: tb/tb_mvprod_rr_sched.sv
// Scoreboard bench for mvprod_rr_sched: expected writes/done pulses queued at drive time.
module tb_mvprod_rr_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  req_valid;
  logic [15:0] in_data_0, in_data_1;
  logic [1:0]  rd_en, wrap_rd, out_wr_en;
  logic [7:0]  out_wr_data;
  logic        mv_in_data_ready;
  logic [15:0] mv_in_data;
  logic        mv_req_chunk_in, mv_req_chunk_ptr_rst, mv_req_chunk_out;
  logic [7:0]  mv_write_out_data;
  logic        mv_out_vector_valid;
  logic        grant_id, busy, err;
  logic [1:0]  done;

  int checks = 0;
  int errors = 0;

  logic [9:0] wq[$];
  logic [1:0] dq[$];
  logic [9:0] w_item;
  logic [1:0] d_item;

  always #5 clk_in = ~clk_in;

  mvprod_rr_sched #(
    .OutVecLength(8), .BytesPerRead(2), .BytesPerWrite(1),
    .RearmCycles(2), .TimeoutCycles(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid(req_valid),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .rd_en(rd_en), .wrap_rd(wrap_rd), .out_wr_en(out_wr_en), .out_wr_data(out_wr_data),
    .mv_in_data_ready(mv_in_data_ready), .mv_in_data(mv_in_data),
    .mv_req_chunk_in(mv_req_chunk_in), .mv_req_chunk_ptr_rst(mv_req_chunk_ptr_rst),
    .mv_req_chunk_out(mv_req_chunk_out), .mv_write_out_data(mv_write_out_data),
    .mv_out_vector_valid(mv_out_vector_valid),
    .grant_id(grant_id), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: every forwarded write and every done pulse must match the queue head.
  always @(negedge clk_in) begin
    if (rst_in === 1'b0) begin
      if (out_wr_en != 2'b00) begin
        if (wq.size() == 0) begin
          check("wr_extra", 32'(out_wr_en), 32'd0);
        end else begin
          w_item = wq.pop_front();
          check("wr_en", 32'(out_wr_en), 32'(w_item[9:8]));
          check("wr_data", 32'(out_wr_data), 32'(w_item[7:0]));
          $display("write en=%b data=%02h", out_wr_en, out_wr_data);
        end
      end
      if (done != 2'b00) begin
        if (dq.size() == 0) begin
          check("done_extra", 32'(done), 32'd0);
        end else begin
          d_item = dq.pop_front();
          check("done", 32'(done), 32'(d_item));
          $display("done=%b", done);
        end
      end
    end
  end

  // One full pass; entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_pass(input logic [1:0] req, input logic hold, input logic exp_g,
                          input logic [7:0] base);
    logic [1:0] mask;
    mask = exp_g ? 2'b10 : 2'b01;
    req_valid = req;
    mv_req_chunk_out = 1'b1;
    mv_write_out_data = 8'hEE;
    @(negedge clk_in);
    check("idle_wr", 32'(out_wr_en), 32'd0);
    check("rdy_pre", 32'(mv_in_data_ready), 32'd0);
    tick();
    mv_req_chunk_out = 1'b0;
    if (!hold) req_valid = 2'b00;
    @(negedge clk_in);
    check("rdy_rise", 32'(mv_in_data_ready), 32'd1);
    check("grant", 32'(grant_id), 32'(exp_g));
    check("busy_run", 32'(busy), 32'd1);
    check("mv_data", 32'(mv_in_data), exp_g ? 32'h1234 : 32'hAAAA);
    tick();
    mv_req_chunk_in = 1'b1;
    @(negedge clk_in);
    check("rd_en", 32'(rd_en), 32'(mask));
    check("wrap_idle", 32'(wrap_rd), 32'd0);
    tick();
    mv_req_chunk_in = 1'b0;
    mv_req_chunk_ptr_rst = 1'b1;
    @(negedge clk_in);
    check("wrap_rd", 32'(wrap_rd), 32'(mask));
    check("rd_idle", 32'(rd_en), 32'd0);
    tick();
    mv_req_chunk_ptr_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mv_req_chunk_out = 1'b1;
      mv_write_out_data = base + 8'(i);
      wq.push_back({mask, base + 8'(i)});
      if (i == 7) dq.push_back(mask);
      @(negedge clk_in);
      tick();
    end
    mv_write_out_data = 8'hEE;
    @(negedge clk_in);
    check("rearm_wr", 32'(out_wr_en), 32'd0);
    check("rearm_rdy1", 32'(mv_in_data_ready), 32'd0);
    check("rearm_busy1", 32'(busy), 32'd1);
    tick();
    mv_req_chunk_out = 1'b0;
    @(negedge clk_in);
    check("rearm_rdy2", 32'(mv_in_data_ready), 32'd0);
    check("rearm_busy2", 32'(busy), 32'd1);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);
    $display("pass grant=%0d base=%02h complete", exp_g, base);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_in = 1'b1;
    req_valid = 2'b00;
    in_data_0 = 16'hAAAA;
    in_data_1 = 16'h1234;
    mv_req_chunk_in = 1'b0;
    mv_req_chunk_ptr_rst = 1'b0;
    mv_req_chunk_out = 1'b0;
    mv_write_out_data = 8'h00;
    mv_out_vector_valid = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(mv_in_data_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_in = 1'b0;
    tick();

    // Single requester
    run_pass(2'b01, 1'b0, 1'b0, 8'h10);

    // Reset after 3 of 8 writes
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      mv_req_chunk_out = 1'b1;
      mv_write_out_data = 8'h30 + 8'(i);
      wq.push_back({2'b01, 8'h30 + 8'(i)});
      @(negedge clk_in);
      tick();
    end
    mv_req_chunk_out = 1'b0;
    rst_in = 1'b1;
    tick();
    check("mid_rst_outs", {rd_en, wrap_rd, out_wr_en, out_wr_data, mv_in_data_ready},
          32'd0);
    check("mid_rst_data", 32'(mv_in_data), 32'd0);
    check("mid_rst_state", {28'd0, grant_id, busy, done}, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst_in = 1'b0;
    tick();
    check("post_rst_done", 32'(done), 32'd0);
    run_pass(2'b10, 1'b0, 1'b1, 8'h40);

    // Contention: both requesters held valid
    run_pass(2'b11, 1'b1, 1'b0, 8'h50);
    run_pass(2'b11, 1'b1, 1'b1, 8'h60);
    run_pass(2'b11, 1'b1, 1'b0, 8'h70);
    run_pass(2'b11, 1'b1, 1'b1, 8'h80);
    req_valid = 2'b00;
    tick();
    check("final_idle", 32'(busy), 32'd0);

`ifdef MVPROD_SCHED_WDT_EN
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) mv_req_chunk_in = 1'b1;
      check("wdt_err", 32'(err), (k == 16) ? 32'd1 : 32'd0);
      if (k == 16) check("wdt_rd_gated", 32'(rd_en), 32'd0);
      tick();
    end
    mv_req_chunk_in = 1'b0;
    check("wdt_err_clr", 32'(err), 32'd0);
    check("wdt_rearm1", {30'd0, busy, mv_in_data_ready}, 32'd2);
    tick();
    check("wdt_rearm2", {30'd0, busy, mv_in_data_ready}, 32'd2);
    tick();
    check("wdt_idle", 32'(busy), 32'd0);
    $display("watchdog pass complete");
`endif

    check("end_wq", 32'(wq.size()), 32'd0);
    check("end_dq", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
